// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   - Default widths for requester count, register address and write data.
//   - hold_entry_t: one buffered write request (valid, addr, data).
//   - id_width(): width of a requester index, never less than one bit.
package rf_write_arbiter_pkg;

    localparam int unsigned NUM_REQ_DEF = 3;
    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF  = 32;

    // Field widths follow the package defaults; instances that widen ADDR_W or
    // DATA_W beyond these need the defaults raised here as well.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } hold_entry_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_picker.sv
// Round-robin picker: combinational search of a valid vector starting at ptr.
// Ports:
//   valid      - per-requester candidate flags
//   ptr        - index where the search starts (must be < NUM_REQ)
//   grant      - one-hot grant, all zero when nothing is valid
//   grant_idx  - index of the granted requester (0 when no grant)
//   any_grant  - high when some requester was granted
module rr_picker
    import rf_write_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int unsigned SUM_W = ID_W + 1;

    logic [SUM_W-1:0] sum;
    logic [ID_W-1:0]  idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!any_grant && valid[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write arbiter.
// Each requester owns a one-entry holding register; valid entries are picked
// round-robin, one per cycle, and the winner is registered onto the write port.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   flush      - synchronous discard of all buffered requests
//   req_valid  - per-requester write request
//   req_ready  - per-requester accept indication
//   req_addr   - packed per-requester destination register (requester i at i*ADDR_W)
//   req_data   - packed per-requester write data (requester i at i*DATA_W)
//   rf_we      - register file write enable (registered)
//   rf_waddr   - register file write address (registered)
//   rf_wdata   - register file write data (registered)
//   grant_id   - requester index of the current write (registered)
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter  int unsigned ADDR_W  = ADDR_W_DEF,
    parameter  int unsigned DATA_W  = DATA_W_DEF,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic [ID_W-1:0]           grant_id
);

    hold_entry_t hold_q [NUM_REQ];
    hold_entry_t hold_d [NUM_REQ];

    logic [NUM_REQ-1:0] hold_valid;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] accept;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;
    logic               issue;

    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic               we_q, we_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [ID_W-1:0]    gid_q, gid_d;

    always_comb begin
        hold_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_valid[i] = hold_q[i].valid;
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid     (hold_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // A flush cycle still computes a grant, but nothing is issued from it.
    assign issue = any_grant && !flush;

    // An entry may be refilled in the same cycle it is granted.
    always_comb begin
        req_ready = '0;
        accept    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && !flush && (!hold_valid[i] || grant[i]);
            accept[i]    = req_valid[i] && req_ready[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_d[i] = hold_q[i];
            if (flush) begin
                hold_d[i].valid = 1'b0;
            end else begin
                if (grant[i]) begin
                    hold_d[i].valid = 1'b0;
                end
                // Writes to x0 are accepted but never buffered.
                if (accept[i] && (req_addr[i*ADDR_W +: ADDR_W] != '0)) begin
                    hold_d[i].valid = 1'b1;
                    hold_d[i].addr  = ADDR_W_DEF'(req_addr[i*ADDR_W +: ADDR_W]);
                    hold_d[i].data  = DATA_W_DEF'(req_data[i*DATA_W +: DATA_W]);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        if (issue) begin
            we_d    = 1'b1;
            waddr_d = ADDR_W'(hold_q[grant_idx].addr);
            wdata_d = DATA_W'(hold_q[grant_idx].data);
            gid_d   = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= '0;
            end
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gid_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= hold_d[i];
            end
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign grant_id = gid_q;

endmodule
